// File: rtl/xnor_popcount_acc.sv
// Accumulates popcount(XNOR(a,b)) over BEATS accepted beats into one result; out_valid 1 cycle after the last beat.
// Result is held until out_ready; in_ready is low while a result is pending.
module xnor_popcount_acc #(
  parameter int WIDTH = 8,
  parameter int BEATS = 4,
  parameter int ACC_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_match
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TOTAL = WIDTH * BEATS;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {S_ACC, S_DONE} state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] same_bits;
  logic [ACC_W-1:0] score;

  assign same_bits = ~(a ^ b);

  always_comb begin
    score = '0;
    for (int i = 0; i < WIDTH; i++) begin
      score = score + ACC_W'(same_bits[i]);
    end
  end

  assign acc_d = acc_q + score;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else if (clr) begin
      // Abort wins over any beat or result handshake this cycle.
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_ACC: begin
          if (in_valid) begin
            if (cnt_q == LAST_BEAT) begin
              sum_q   <= acc_d;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_DONE;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_ACC;
          end
        end
        default: state_q <= S_ACC;
      endcase
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = sum_q;
  assign out_match = out_valid && (sum_q == ACC_W'(TOTAL));

endmodule

// File: doc/xnor_popcount_acc.md
XNOR_POPCOUNT_ACC -- requirements
Module: xnor_popcount_acc

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8, which is the operand width in bits (minimum 1).
REQ-002 The module SHALL take parameter BEATS, default 4, which is the number of operand beats per result (minimum 1).
REQ-003 The module SHALL take parameter ACC_W, default 6, which is the accumulator/result width and SHALL be >= clog2(WIDTH*BEATS+1).
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 clr  input  1  synchronous abort; discards the partial or pending result.
REQ-007 in_valid  input  1  operand beat present on a/b.
REQ-008 in_ready  output  1  module accepts a beat this cycle.
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B.
REQ-011 out_valid  output  1  result present on out_sum/out_match.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 out_sum  output  ACC_W  total count of equal bit positions over BEATS beats.
REQ-014 out_match  output  1  high when out_sum == WIDTH*BEATS (all bits equal).

Function
REQ-015 The module SHALL implement two states: ACC (collecting beats) and DONE (holding a result).
REQ-016 Beat score: popcount of bitwise XNOR(a, b), range 0..WIDTH.
REQ-017 In ACC: in_ready=1 and out_valid=0; a beat is accepted when in_valid && in_ready at the rising edge.
REQ-018 Accepted beat: acc <= acc + score and beat_cnt <= beat_cnt + 1; cycles with in_valid=0 SHALL leave acc and beat_cnt unchanged.
REQ-019 On acceptance of beat number BEATS: out_sum <= acc + score, the state SHALL go to DONE, and out_valid SHALL be 1 in the next cycle (latency 1 cycle from the final beat).
REQ-020 In DONE: in_ready=0, out_valid=1, and out_sum/out_match SHALL be held stable until the handshake completes.
REQ-021 A result handshake (out_valid && out_ready) SHALL clear acc and beat_cnt and return the state to ACC; in_ready SHALL be 1 in the next cycle (no same-cycle bypass).
REQ-022 Arithmetic SHALL be unsigned; by the REQ-003 sizing, acc never wraps; beat_cnt SHALL wrap from BEATS-1 back to 0 only via REQ-019/021.
REQ-023 out_match SHALL be combinational from registered out_sum and SHALL be 0 whenever out_valid=0.
REQ-024 clr=1 in any state: acc=0, beat_cnt=0, state=ACC, out_valid=0 next cycle; any in-flight beat or pending result SHALL be dropped.
REQ-025 clr and a beat acceptance in the same cycle: clr SHALL win and the beat is discarded.
REQ-026 BEATS=1: every accepted beat SHALL go directly to DONE.

Reset
REQ-027 rst=1 at a rising edge SHALL force state=ACC, acc=0, beat_cnt=0, out_sum=0, out_valid=0, and in_ready=1 from the following cycle.
REQ-028 rst SHALL take priority over clr and over all handshakes, including mid-accumulation and in DONE.

Verification (WIDTH=8, BEATS=4, ACC_W=6)
REQ-029 4 back-to-back beats a=b=8'h5A -> out_valid 1 cycle after beat 4, out_sum=32, out_match=1.
REQ-030 4 beats a=8'hFF, b=8'h00 -> out_sum=0, out_match=0.
REQ-031 Beats (0F,0F),(F0,0F),(AA,AB),(00,00) with in_valid gaps of 0, 2, and 1 idle cycles -> out_sum=23, out_match=0.
REQ-032 Result pending with out_ready low for 3 cycles -> out_sum held at its value, in_ready=0 throughout, and a beat offered meanwhile is not accepted; after out_ready=1 for 1 cycle, in_ready=1 on the next cycle.
REQ-033 rst (or clr) asserted after 2 accepted beats of a=b=FF, then 4 beats of (FF,FE) -> out_sum=28, confirming the partial accumulation was discarded.
REQ-034 clr asserted in the same cycle as the 4th beat -> no out_valid; the next 4 beats of a=b=00 -> out_sum=32.
